// File: rtl/cordic_range_reduce.sv
// Reduces an arbitrary signed fixed-point angle modulo 2*pi into [-pi/2, pi/2]
// for the CORDIC sin/cos core, plus a flag telling writeback to negate sin and cos.
module cordic_range_reduce #(
  parameter int unsigned FRAC_BITS     = 32,
  parameter int unsigned KMAX          = 28,
  parameter int unsigned OP_BITS       = 4,
  parameter int unsigned TRANS_ID_BITS = 3,
  parameter logic [63:0] TWO_PI        = 64'h0000_0006_487E_D511,
  parameter logic [63:0] PI            = 64'h0000_0003_243F_6A89,
  parameter logic [63:0] HALF_PI       = 64'h0000_0001_921F_B544,
  parameter logic [63:0] THREE_HALF_PI = 64'h0000_0004_B65F_1FCD
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic                     valid_i,
  output logic                     ready_o,
  input  logic [63:0]              angle_i,
  input  logic [OP_BITS-1:0]       op_i,
  input  logic [TRANS_ID_BITS-1:0] trans_id_i,
  output logic                     valid_o,
  input  logic                     ready_i,
  output logic [63:0]              angle_o,
  output logic                     neg_o,
  output logic [OP_BITS-1:0]       op_o,
  output logic [TRANS_ID_BITS-1:0] trans_id_o,
  output logic [1:0]               state_o
);

  // Handshake: a transfer happens on a rising edge where valid and ready are both
  // high; valid, once raised, holds with its data stable until that edge, and
  // neither ready_o nor valid_o depends combinationally on any input.

  if (FRAC_BITS >= 63 || KMAX > 31) begin : g_bad_params
    $error("cordic_range_reduce: FRAC_BITS or KMAX out of range");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REDUCE = 2'd1,
    FIX    = 2'd2,
    OUT    = 2'd3
  } state_e;

  localparam logic [4:0] K_INIT = 5'(KMAX);

  state_e      state_q;
  logic [63:0] r_q;
  logic        s_q;
  logic [4:0]  k_q;

  logic [63:0] step;
  logic [63:0] r_fold;
  logic [63:0] fix_angle;
  logic        fix_neg;

  assign state_o = state_q;
  assign step    = TWO_PI << k_q;

  // Negative inputs were reduced as magnitudes; fold them back onto [0, 2*pi).
  always_comb begin
    r_fold    = (s_q && (r_q != 64'd0)) ? (TWO_PI - r_q) : r_q;
    fix_angle = r_fold;
    fix_neg   = 1'b0;
    if (r_fold <= HALF_PI) begin
      fix_angle = r_fold;
      fix_neg   = 1'b0;
    end else if (r_fold <= THREE_HALF_PI) begin
      fix_angle = r_fold - PI;
      fix_neg   = 1'b1;
    end else begin
      fix_angle = r_fold - TWO_PI;
      fix_neg   = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      ready_o    <= 1'b1;
      valid_o    <= 1'b0;
      angle_o    <= '0;
      neg_o      <= 1'b0;
      op_o       <= '0;
      trans_id_o <= '0;
      r_q        <= '0;
      s_q        <= 1'b0;
      k_q        <= '0;
    end else if (flush_i) begin
      state_q <= IDLE;
      ready_o <= 1'b1;
      valid_o <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (valid_i && ready_o) begin
            // Unsigned magnitude, so the most negative angle maps to 2^63 cleanly.
            r_q        <= angle_i[63] ? (~angle_i + 64'd1) : angle_i;
            s_q        <= angle_i[63];
            op_o       <= op_i;
            trans_id_o <= trans_id_i;
            k_q        <= K_INIT;
            ready_o    <= 1'b0;
            state_q    <= REDUCE;
          end
        end
        REDUCE: begin
          if (r_q >= step) begin
            r_q <= r_q - step;
          end
          if (k_q == 5'd0) begin
            state_q <= FIX;
          end else begin
            k_q <= k_q - 5'd1;
          end
        end
        FIX: begin
          angle_o <= fix_angle;
          neg_o   <= fix_neg;
          valid_o <= 1'b1;
          state_q <= OUT;
        end
        OUT: begin
          if (ready_i) begin
            valid_o <= 1'b0;
            ready_o <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
          ready_o <= 1'b1;
          valid_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_range_reduce.sv
// Directed bench for cordic_range_reduce: angle-mod-2*pi model, expected queue,
// per-cycle output compare, handshake/flush/reset scenarios.
module tb_cordic_range_reduce;

  localparam int OP_BITS       = 4;
  localparam int TID_BITS      = 3;
  localparam int W             = 64 + 1 + OP_BITS + TID_BITS;
  localparam int LATENCY       = 30;
  localparam logic [63:0] TWO_PI  = 64'h0000_0006_487E_D511;
  localparam logic [63:0] PI      = 64'h0000_0003_243F_6A89;
  localparam logic [63:0] HALF_PI = 64'h0000_0001_921F_B544;

  logic                clk_i = 1'b0;
  logic                rst_ni;
  logic                flush_i;
  logic                valid_i;
  logic                ready_o;
  logic [63:0]         angle_i;
  logic [OP_BITS-1:0]  op_i;
  logic [TID_BITS-1:0] trans_id_i;
  logic                valid_o;
  logic                ready_i;
  logic [63:0]         angle_o;
  logic                neg_o;
  logic [OP_BITS-1:0]  op_o;
  logic [TID_BITS-1:0] trans_id_o;
  logic [1:0]          state_o;

  cordic_range_reduce #(
    .OP_BITS       (OP_BITS),
    .TRANS_ID_BITS (TID_BITS)
  ) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .flush_i    (flush_i),
    .valid_i    (valid_i),
    .ready_o    (ready_o),
    .angle_i    (angle_i),
    .op_i       (op_i),
    .trans_id_i (trans_id_i),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .angle_o    (angle_o),
    .neg_o      (neg_o),
    .op_o       (op_o),
    .trans_id_o (trans_id_o),
    .state_o    (state_o)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk_i = ~clk_i;

  int unsigned cyc = 0;
  int unsigned acc_cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;
  logic valid_prev = 1'b0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Angle modulo 2*pi folded into [-pi/2, pi/2]; returns {neg, angle}.
  function automatic logic [64:0] model(input logic [63:0] a);
    logic [63:0] mag;
    logic [63:0] m;
    mag = a[63] ? (64'd0 - a) : a;
    m = mag % TWO_PI;
    if (a[63] && m != 64'd0) m = TWO_PI - m;
    if (m <= HALF_PI)           return {1'b0, m};
    else if (m <= HALF_PI + PI) return {1'b1, m - PI};
    else                        return {1'b0, m - TWO_PI};
  endfunction

  // ---------------- compare process ----------------
  always @(negedge clk_i) begin
    logic [W-1:0] e;
    if (rst_ni && valid_o) begin
      check("ready_low_in_out", {63'd0, ready_o}, 64'd0);
      check("angle_in_range", {63'd0, ($signed(angle_o) <= $signed(HALF_PI)) &&
                                      ($signed(angle_o) >= -$signed(HALF_PI))}, 64'd1);
      if (exp_q.size() == 0) begin
        check("unexpected_valid", 64'd1, 64'd0);
      end else begin
        e = exp_q[0];
        check("angle_o", angle_o, e[W-1 -: 64]);
        check("neg_o", {63'd0, neg_o}, {63'd0, e[OP_BITS+TID_BITS]});
        check("op_o", 64'(op_o), 64'(e[OP_BITS+TID_BITS-1 -: OP_BITS]));
        check("trans_id_o", 64'(trans_id_o), 64'(e[TID_BITS-1:0]));
        if (!valid_prev) check("latency", 64'(cyc - acc_cyc), 64'(LATENCY));
        if (ready_i) void'(exp_q.pop_front());
      end
    end
    valid_prev = valid_o;
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [63:0] a, input logic [OP_BITS-1:0] op,
                      input logic [TID_BITS-1:0] tid);
    int n;
    logic [64:0] m;
    n = 0;
    angle_i = a; op_i = op; trans_id_i = tid; valid_i = 1'b1;
    while (!ready_o && n < 200) begin
      @(posedge clk_i); #1; n++;
    end
    if (!ready_o) begin
      check("send_timeout", 64'd1, 64'd0);
      valid_i = 1'b0;
      return;
    end
    @(posedge clk_i);
    m = model(a);
    exp_q.push_back({m[63:0], m[64], op, tid});
    #1;
    acc_cyc = cyc;
    valid_i = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk_i); #1; n++;
    end
    check("drain_timeout", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    while (!valid_o && n < 200) begin
      @(posedge clk_i); #1; n++;
    end
    check("wait_valid_timeout", {63'd0, valid_o}, 64'd1);
  endtask

  task automatic run_vec(input logic [63:0] a, input bit has_lit, input logic [63:0] ea,
                         input logic en, input logic [OP_BITS-1:0] op,
                         input logic [TID_BITS-1:0] tid);
    logic [64:0] m;
    m = model(a);
    if (has_lit) begin
      check("model_angle", m[63:0], ea);
      check("model_neg", {63'd0, m[64]}, {63'd0, en});
    end
    send(a, op, tid);
    wait_done();
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_ready_o"}, {63'd0, ready_o}, 64'd1);
    check({tag, "_valid_o"}, {63'd0, valid_o}, 64'd0);
    check({tag, "_angle_o"}, angle_o, 64'd0);
    check({tag, "_neg_o"}, {63'd0, neg_o}, 64'd0);
    check({tag, "_op_o"}, 64'(op_o), 64'd0);
    check({tag, "_trans_id_o"}, 64'(trans_id_o), 64'd0);
    check({tag, "_state_o"}, 64'(state_o), 64'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst_ni = 1'b0; flush_i = 1'b0; valid_i = 1'b0; ready_i = 1'b1;
    angle_i = '0; op_i = '0; trans_id_i = '0;
    repeat (3) @(posedge clk_i);
    #1;
    check_reset_vals("in_reset");
    rst_ni = 1'b1;
    @(posedge clk_i); #1;
    check_reset_vals("after_reset");

    run_vec(64'h0000_0001_0000_0000, 1, 64'h0000_0001_0000_0000, 1'b0, 4'h1, 3'd1);
    run_vec(PI,                      1, 64'd0,                   1'b1, 4'h2, 3'd2);
    run_vec(HALF_PI,                 1, HALF_PI,                 1'b0, 4'h1, 3'd3);
    run_vec(64'hFFFF_FFFF_0000_0000, 1, 64'hFFFF_FFFF_0000_0000, 1'b0, 4'h2, 3'd4);
    run_vec(64'd0,                   1, 64'd0,                   1'b0, 4'h1, 3'd5);
    run_vec(64'h0000_0065_07ED_5110, 1, 64'h0000_0000_8000_0000, 1'b0, 4'h2, 3'd6);
    run_vec(64'hFFFF_FF9A_F812_AEF0, 1, 64'hFFFF_FFFF_8000_0000, 1'b0, 4'h1, 3'd7);
    run_vec(64'h8000_0000_0000_0000, 0, 64'd0,                   1'b0, 4'h2, 3'd0);

    // Two back-to-back angles, second waits on ready_o.
    send(64'hFFFF_FFFE_0000_0000, 4'h3, 3'd1);
    send(64'h0000_0002_0000_0000, 4'h1, 3'd2);
    wait_done();

    // Downstream stall in OUT with a competing valid_i.
    check("model_2rad", model(64'h0000_0002_0000_0000),
          {1'b1, 64'hFFFF_FFFE_DBC0_9577});
    ready_i = 1'b0;
    send(64'h0000_0002_0000_0000, 4'h3, 3'd5);
    wait_valid();
    for (int i = 0; i < 5; i++) begin
      valid_i = 1'b1; angle_i = 64'h0000_0000_1234_5678; op_i = 4'h1; trans_id_i = 3'd6;
      @(posedge clk_i); #1;
      check("stall_valid_o", {63'd0, valid_o}, 64'd1);
      check("stall_ready_o", {63'd0, ready_o}, 64'd0);
      check("stall_trans_id", 64'(trans_id_o), 64'd5);
      check("stall_op", 64'(op_o), 64'd3);
      check("stall_angle", angle_o, 64'hFFFF_FFFE_DBC0_9577);
    end
    valid_i = 1'b0; ready_i = 1'b1;
    @(posedge clk_i); #1;
    check("post_hs_ready_o", {63'd0, ready_o}, 64'd1);
    check("post_hs_valid_o", {63'd0, valid_o}, 64'd0);
    check("post_hs_queue", 64'(exp_q.size()), 64'd0);
    repeat (40) @(posedge clk_i);
    #1;

    // Flush mid-REDUCE.
    send(64'h0000_0003_0000_0000, 4'h1, 3'd2);
    repeat (10) @(posedge clk_i);
    #1;
    check("pre_flush_ready_o", {63'd0, ready_o}, 64'd0);
    flush_i = 1'b1;
    @(posedge clk_i); #1;
    flush_i = 1'b0;
    exp_q.delete();
    check("flush_valid_o", {63'd0, valid_o}, 64'd0);
    check("flush_ready_o", {63'd0, ready_o}, 64'd1);
    check("flush_state_o", 64'(state_o), 64'd0);
    // valid_i coinciding with flush is dropped.
    valid_i = 1'b1; angle_i = 64'h0000_0001_0000_0000; flush_i = 1'b1;
    @(posedge clk_i); #1;
    valid_i = 1'b0; flush_i = 1'b0;
    check("flush_drop_ready_o", {63'd0, ready_o}, 64'd1);
    check("flush_drop_state_o", 64'(state_o), 64'd0);
    repeat (40) @(posedge clk_i);
    #1;
    run_vec(64'hFFFF_FFFE_0000_0000, 1, 64'h0000_0001_243F_6A88, 1'b1, 4'h2, 3'd3);

    // Asynchronous reset mid-REDUCE.
    send(64'h0000_0001_0000_0000, 4'h3, 3'd7);
    repeat (10) @(posedge clk_i);
    #1;
    rst_ni = 1'b0;
    #1;
    exp_q.delete();
    check_reset_vals("mid_reset");
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    repeat (40) @(posedge clk_i);
    #1;
    check_reset_vals("post_mid_reset");
    run_vec(64'h0000_0001_0000_0000, 1, 64'h0000_0001_0000_0000, 1'b0, 4'h1, 3'd4);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
